// File: rtl/cgra_pkg.sv
// Shared sizing constants and state encoding for the STRELA CGRA memory nodes.
// The output node buffers ODM results in a FIFO and limits in-flight OBI writes.
package cgra_pkg;

  localparam int unsigned FIFO_DEPTH        = 4;
  localparam int unsigned FIFO_PTR_WIDTH    = $clog2(FIFO_DEPTH);
  localparam int unsigned MAX_OUTSTANDING   = 2;
  // Sized so the counter can hold MAX_OUTSTANDING itself without wrapping.
  localparam int unsigned OUTSTANDING_WIDTH = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } omn_state_t;

endpackage

// File: rtl/obi_pkg.sv
// OBI request/response bundles shared by the CGRA input and output memory nodes.
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/fifo_v3.sv
// Synchronous FIFO with registered storage; the head is read from storage,
// so a word written this cycle is visible at data_o on the next cycle.
module fifo_v3
  import cgra_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = FIFO_DEPTH,
  parameter int unsigned ADDR_DEPTH = FIFO_PTR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  localparam int unsigned CNT_WIDTH = ADDR_DEPTH + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_DEPTH-1:0] rd_ptr_q;
  logic [ADDR_DEPTH-1:0] wr_ptr_q;
  logic [CNT_WIDTH-1:0]  count_q;
  logic                  do_push;
  logic                  do_pop;

  function automatic logic [ADDR_DEPTH-1:0] ptr_inc(input logic [ADDR_DEPTH-1:0] ptr);
    return (ptr == ADDR_DEPTH'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full_o  = (count_q == CNT_WIDTH'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // NOTE: registers are updated with non-blocking assignments so every flop
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; clearing the pointers
  // and count makes stale contents unreachable, and reset-free RAM maps cleanly.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/output_memory_node.sv
// Output memory node: accepts ODM result words, buffers them and writes them to
// memory over OBI at base + k*stride, raising done_o once every write is acked.
module output_memory_node
  import cgra_pkg::*;
  import obi_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        execute_i,
  input  logic [31:0] output_addr_i,
  input  logic [15:0] output_size_i,
  input  logic [15:0] output_stride_i,
  output obi_req_t    masters_req_o,
  input  obi_resp_t   masters_resp_i,
  input  logic [31:0] din_i,
  input  logic        din_v_i,
  output logic        din_r_o,
  output logic        done_o
);

  omn_state_t                   state_q, state_d;
  logic [16:0]                  acc_offset_q, acc_offset_d;
  logic [16:0]                  wr_offset_q, wr_offset_d;
  logic [16:0]                  n_wr_offset;
  logic [16:0]                  size_ext;
  logic [16:0]                  stride_ext;
  logic [OUTSTANDING_WIDTH-1:0] outstanding_q, outstanding_d;

  logic        fifo_full;
  logic        fifo_empty;
  logic [31:0] fifo_head;
  logic        push;
  logic        req;
  logic        grant;
  logic        rvalid;
  logic        unused_rdata;

  // Offsets are one bit wider than size so the final increment cannot wrap
  // back below size and re-enable acceptance or writes.
  assign size_ext    = {1'b0, output_size_i};
  assign stride_ext  = {1'b0, output_stride_i};
  assign n_wr_offset = wr_offset_q + stride_ext;

  assign din_r_o = (state_q == S_WRITE) & ~fifo_full & (acc_offset_q < size_ext);
  assign push    = din_v_i & din_r_o;

  assign req   = (state_q == S_WRITE) & ~fifo_empty
               & (outstanding_q < OUTSTANDING_WIDTH'(MAX_OUTSTANDING));
  assign grant = req & masters_resp_i.gnt;

  // A response with nothing in flight (e.g. one that straddled a reset) is dropped.
  assign rvalid = masters_resp_i.rvalid & ((outstanding_q != '0) | grant);

  assign unused_rdata = ^masters_resp_i.rdata;

  // Popping only on grant keeps addr/wdata stable while a request is stalled.
  assign masters_req_o = '{
    req:   req,
    we:    1'b1,
    be:    4'hF,
    addr:  output_addr_i + {15'b0, wr_offset_q},
    wdata: fifo_head
  };

  assign done_o = (state_q == S_DONE);

  fifo_v3 #(
    .DATA_WIDTH (32),
    .DEPTH      (FIFO_DEPTH),
    .ADDR_DEPTH (FIFO_PTR_WIDTH)
  ) fifo_i (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .data_i  (din_i),
    .push_i  (push),
    .data_o  (fifo_head),
    .pop_i   (grant)
  );

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    acc_offset_d  = acc_offset_q;
    wr_offset_d   = wr_offset_q;
    outstanding_d = outstanding_q;

    unique case ({grant, rvalid})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: ;
    endcase

    if (push)  acc_offset_d = acc_offset_q + stride_ext;
    if (grant) wr_offset_d  = n_wr_offset;

    unique case (state_q)
      S_IDLE: begin
        if (execute_i) state_d = (output_size_i != '0) ? S_WRITE : S_DONE;
      end
      S_WRITE: begin
        // Last write granted; skip the drain if its ack already settled the count.
        if (grant && (n_wr_offset >= size_ext)) begin
          state_d = (outstanding_d == '0) ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (outstanding_d == '0) state_d = S_DONE;
      end
      S_DONE: begin
        if (!execute_i) begin
          state_d       = S_IDLE;
          acc_offset_d  = '0;
          wr_offset_d   = '0;
          outstanding_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      acc_offset_q  <= '0;
      wr_offset_q   <= '0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      acc_offset_q  <= acc_offset_d;
      wr_offset_q   <= wr_offset_d;
      outstanding_q <= outstanding_d;
    end
  end

endmodule

// File: tb/tb_output_memory_node.sv
// Self-checking bench for output_memory_node: an ODM driver, an OBI memory model
// with programmable latency and stalls, and a scoreboard of expected writes.
module tb_output_memory_node;
  import cgra_pkg::*;
  import obi_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        execute;
  logic [31:0] base;
  logic [15:0] size;
  logic [15:0] stride;
  obi_req_t    mreq;
  obi_resp_t   mresp = '0;
  logic [31:0] din = '0;
  logic        din_v = 1'b0;
  logic        din_r;
  logic        done;

  always #5 clk = ~clk;

  output_memory_node dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .execute_i       (execute),
    .output_addr_i   (base),
    .output_size_i   (size),
    .output_stride_i (stride),
    .masters_req_o   (mreq),
    .masters_resp_i  (mresp),
    .din_i           (din),
    .din_v_i         (din_v),
    .din_r_o         (din_r),
    .done_o          (done)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] tx_q[$];
  wr_t         sb_q[$];
  int          pending_q[$];
  int          latency = 1;
  int          stall_idx = -1;
  int          stall_len = 0;
  int          stall_cnt = 0;
  int          grant_cnt = 0;
  int          rv_cnt = 0;
  int          acc_cnt = 0;
  int          exp_words = 0;
  int          gate_checks = 0;
  logic [31:0] stall_addr;
  logic [31:0] stall_data;
  logic        acc_flag = 1'b0;
  logic        rv_next;
  logic        gnt_next;
  wr_t         exp_w;

  // Memory model and monitor: decides gnt/rvalid for the coming edge and
  // observes the handshakes that edge will complete.
  always @(negedge clk) begin
    if (!rst_ni) begin
      mresp.gnt    = 1'b0;
      mresp.rvalid = 1'b0;
      acc_flag     = 1'b0;
    end else begin
      rv_next = 1'b0;
      foreach (pending_q[i]) pending_q[i]--;
      if (pending_q.size() > 0 && pending_q[0] <= 0) begin
        void'(pending_q.pop_front());
        rv_next = 1'b1;
      end

      if ((grant_cnt - rv_cnt) >= int'(MAX_OUTSTANDING)) begin
        checks++;
        gate_checks++;
        if (mreq.req !== 1'b0) begin
          errors++;
          $display("FAIL req_gated: req=%b with %0d in flight, required 0", mreq.req, grant_cnt - rv_cnt);
        end
      end

      gnt_next = 1'b1;
      if (mreq.req && grant_cnt == stall_idx && stall_cnt < stall_len) begin
        gnt_next = 1'b0;
        if (stall_cnt == 0) begin
          stall_addr = mreq.addr;
          stall_data = mreq.wdata;
        end else begin
          checks++;
          if (mreq.addr !== stall_addr || mreq.wdata !== stall_data) begin
            errors++;
            $display("FAIL stall_stable: addr=%h wdata=%h, required addr=%h wdata=%h",
                     mreq.addr, mreq.wdata, stall_addr, stall_data);
          end
        end
        if (stall_cnt == stall_len - 1) begin
          checks++;
          if (din_r !== 1'b0) begin
            errors++;
            $display("FAIL din_r_full: din_r_o=%b with FIFO full, required 0", din_r);
          end
        end
        stall_cnt++;
      end
      mresp.gnt    = gnt_next;
      mresp.rvalid = rv_next;
      if (rv_next) rv_cnt++;

      if (mreq.req && gnt_next) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL write_unexpected: addr=%h wdata=%h, required no write", mreq.addr, mreq.wdata);
        end else begin
          exp_w = sb_q.pop_front();
          if (mreq.addr !== exp_w.addr || mreq.wdata !== exp_w.data || mreq.we !== 1'b1 || mreq.be !== 4'hF) begin
            errors++;
            $display("FAIL write_%0d: addr=%h wdata=%h we=%b be=%h, required addr=%h wdata=%h we=1 be=f",
                     grant_cnt, mreq.addr, mreq.wdata, mreq.we, mreq.be, exp_w.addr, exp_w.data);
          end
        end
        grant_cnt++;
        pending_q.push_back(latency);
      end

      acc_flag = din_v && din_r;
      if (acc_flag) begin
        sb_q.push_back('{addr: base + 32'(acc_cnt) * {16'b0, stride}, data: din});
        acc_cnt++;
      end

      if (done === 1'b1) begin
        checks++;
        if (rv_cnt != exp_words) begin
          errors++;
          $display("FAIL done_early: done_o=1 after %0d rvalids, required %0d", rv_cnt, exp_words);
        end
      end
    end
  end

  // ODM driver: offers the head of tx_q, advancing after each accepted word.
  always begin
    @(posedge clk);
    #1;
    if (acc_flag && tx_q.size() > 0) void'(tx_q.pop_front());
    din_v = (tx_q.size() > 0);
    din   = din_v ? tx_q[0] : 32'h0;
  end

  task automatic setup_run(input logic [31:0] b, input logic [15:0] sz, input logic [15:0] st,
                           input int lat, input int n_offer, input logic [31:0] d0, input int n_exp);
    @(negedge clk);
    #1;
    base        = b;
    size        = sz;
    stride      = st;
    latency     = lat;
    exp_words   = n_exp;
    stall_idx   = -1;
    stall_len   = 0;
    stall_cnt   = 0;
    grant_cnt   = 0;
    rv_cnt      = 0;
    acc_cnt     = 0;
    gate_checks = 0;
    sb_q.delete();
    pending_q.delete();
    tx_q.delete();
    for (int i = 0; i < n_offer; i++) tx_q.push_back(d0 + 32'(i));
    execute = 1'b1;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic stop_run();
    @(negedge clk);
    #1;
    execute = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_ni  = 1'b0;
    execute = 1'b0;
    base    = 32'h1234_0000;
    size    = 16'd16;
    stride  = 16'd4;
    #1;
    checks++;
    if (mreq.req !== 1'b0 || mreq.we !== 1'b1 || mreq.be !== 4'hF || mreq.addr !== 32'h1234_0000) begin
      errors++;
      $display("FAIL reset_obi: req=%b we=%b be=%h addr=%h, required req=0 we=1 be=f addr=12340000",
               mreq.req, mreq.we, mreq.be, mreq.addr);
    end
    checks++;
    if (din_r !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: din_r_o=%b done_o=%b, required 0 0", din_r, done);
    end
    repeat (3) @(negedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_basic_stride();
    bit ok;
    setup_run(32'h1000, 16'd16, 16'd4, 1, 4, 32'hA, 4);
    wait_done(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_done: done_o never rose, required 1"); end
    checks++;
    if (grant_cnt != 4 || rv_cnt != 4 || acc_cnt != 4 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL basic_counts: grants=%0d rvalids=%0d accepted=%0d left=%0d, required 4 4 4 0",
               grant_cnt, rv_cnt, acc_cnt, sb_q.size());
    end
    stop_run();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL basic_idle: done_o=%b, required 0", done); end
  endtask

  task automatic test_backpressure();
    bit ok;
    setup_run(32'h4000, 16'd32, 16'd4, 1, 8, 32'h100, 8);
    stall_idx = 1;
    stall_len = 5;
    wait_done(300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_done: done_o never rose, required 1"); end
    checks++;
    if (stall_cnt != 5 || grant_cnt != 8 || sb_q.size() != 0 || tx_q.size() != 0) begin
      errors++;
      $display("FAIL bp_counts: stalls=%0d grants=%0d left=%0d unsent=%0d, required 5 8 0 0",
               stall_cnt, grant_cnt, sb_q.size(), tx_q.size());
    end
    stop_run();
  endtask

  task automatic test_drain();
    bit ok;
    setup_run(32'h2000, 16'd16, 16'd4, 8, 4, 32'h20, 4);
    wait_done(300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL drain_done: done_o never rose, required 1"); end
    checks++;
    if (rv_cnt != 4 || grant_cnt != 4 || gate_checks == 0) begin
      errors++;
      $display("FAIL drain_counts: rvalids=%0d grants=%0d gated_cycles=%0d, required 4 4 >0",
               rv_cnt, grant_cnt, gate_checks);
    end
    stop_run();
  endtask

  task automatic test_boundary();
    bit ok;
    setup_run(32'h8000_0000, 16'hFFFF, 16'h8000, 2, 3, 32'h50, 2);
    wait_done(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bound_done: done_o never rose, required 1"); end
    checks++;
    if (grant_cnt != 2 || acc_cnt != 2 || tx_q.size() != 1 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL bound_counts: grants=%0d accepted=%0d unsent=%0d left=%0d, required 2 2 1 0",
               grant_cnt, acc_cnt, tx_q.size(), sb_q.size());
    end
    checks++;
    if (din_v !== 1'b1 || din_r !== 1'b0) begin
      errors++;
      $display("FAIL bound_extra: din_v_i=%b din_r_o=%b, required 1 0", din_v, din_r);
    end
    stop_run();
  endtask

  task automatic test_zero_size();
    setup_run(32'h5000, 16'd0, 16'd4, 1, 1, 32'h77, 0);
    @(negedge clk);
    #1;
    checks++;
    if (done !== 1'b1 || mreq.req !== 1'b0 || din_r !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: done_o=%b req=%b din_r_o=%b, required 1 0 0", done, mreq.req, din_r);
    end
    stop_run();
    checks++;
    if (done !== 1'b0 || mreq.req !== 1'b0 || acc_cnt != 0) begin
      errors++;
      $display("FAIL zero_idle: done_o=%b req=%b accepted=%0d, required 0 0 0", done, mreq.req, acc_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    setup_run(32'h6000, 16'd32, 16'd4, 3, 8, 32'h300, 8);
    n = 0;
    while (grant_cnt < 2 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (grant_cnt < 2) begin errors++; $display("FAIL rst_grants: grants=%0d, required 2", grant_cnt); end
    @(negedge clk);
    #1;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (mreq.req !== 1'b0 || din_r !== 1'b0 || done !== 1'b0 || mreq.we !== 1'b1 ||
        mreq.be !== 4'hF || mreq.addr !== 32'h6000) begin
      errors++;
      $display("FAIL rst_mid: req=%b din_r_o=%b done_o=%b we=%b be=%h addr=%h, required 0 0 0 1 f 00006000",
               mreq.req, din_r, done, mreq.we, mreq.be, mreq.addr);
    end
    execute = 1'b0;
    tx_q.delete();
    sb_q.delete();
    pending_q.delete();
    grant_cnt = 0;
    rv_cnt    = 0;
    repeat (2) @(negedge clk);
    #1;
    rst_ni = 1'b1;
    setup_run(32'h6000, 16'd8, 16'd4, 1, 2, 32'h400, 2);
    wait_done(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rerun_done: done_o never rose, required 1"); end
    checks++;
    if (grant_cnt != 2 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL rerun_counts: grants=%0d left=%0d, required 2 0", grant_cnt, sb_q.size());
    end
    stop_run();
  endtask

  initial begin
    test_reset();
    test_basic_stride();
    test_backpressure();
    test_drain();
    test_boundary();
    test_zero_size();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
